// File: rtl/eth_tx_frame_sequencer.sv
// Frame sequencer for the UDP/IPv4 transmit path: round-robin source arbitration,
// header/payload segment sequencing, byte-stream merge, inter-frame gap and stall abort.
module eth_tx_frame_sequencer #(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned ETH_HDR_LEN = 14,
    parameter int unsigned IP_HDR_LEN  = 20,
    parameter int unsigned UDP_HDR_LEN = 8,
    parameter int unsigned PAYLOAD_LEN = 18,
    parameter int unsigned IFG_CYCLES  = 12,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     req_i,
    output logic [NUM_SRC-1:0]     grant_o,
    output logic                   eth_start_o,
    input  logic [7:0]             eth_data_i,
    input  logic                   eth_valid_i,
    output logic                   ip_start_o,
    input  logic [7:0]             ip_data_i,
    input  logic                   ip_valid_i,
    output logic                   udp_start_o,
    input  logic [7:0]             udp_data_i,
    input  logic                   udp_valid_i,
    output logic [NUM_SRC-1:0]     pay_start_o,
    input  logic [8*NUM_SRC-1:0]   pay_data_i,
    input  logic [NUM_SRC-1:0]     pay_valid_i,
    output logic [7:0]             tx_data_o,
    output logic                   tx_valid_o,
    output logic                   tx_sof_o,
    output logic                   tx_eof_o,
    output logic                   err_timeout_o,
    output logic [15:0]            frames_sent_o
);

    localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned SUM_W  = SRC_W + 1;
    localparam int unsigned BYTE_W = $clog2(ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN + PAYLOAD_LEN + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned IFG_W  = $clog2(IFG_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ETH,
        S_IP,
        S_UDP,
        S_PAY,
        S_IFG
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]     ptr_q, ptr_d;
    logic [BYTE_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic [IFG_W-1:0]     ifg_cnt_q, ifg_cnt_d;
    logic                 eth_start_q, eth_start_d;
    logic                 ip_start_q, ip_start_d;
    logic                 udp_start_q, udp_start_d;
    logic [NUM_SRC-1:0]   pay_start_q, pay_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 tx_sof_q, tx_sof_d;
    logic                 tx_eof_q, tx_eof_d;
    logic                 err_q, err_d;
    logic [15:0]          frames_q, frames_d;

    logic                 arb_found_c;
    logic [SRC_W-1:0]     arb_idx_c;
    logic [SUM_W-1:0]     arb_sum_c;
    logic                 seg_valid_c;
    logic [7:0]           seg_data_c;
    logic [BYTE_W-1:0]    seg_last_c;

    // Round-robin: first requester strictly after the pointer, wrapping.
    always_comb begin
        arb_found_c = 1'b0;
        arb_idx_c   = '0;
        arb_sum_c   = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            arb_sum_c = SUM_W'(ptr_q) + SUM_W'(i);
            if (arb_sum_c >= SUM_W'(NUM_SRC)) begin
                arb_sum_c = arb_sum_c - SUM_W'(NUM_SRC);
            end
            if (!arb_found_c && req_i[arb_sum_c[SRC_W-1:0]]) begin
                arb_found_c = 1'b1;
                arb_idx_c   = arb_sum_c[SRC_W-1:0];
            end
        end
    end

    // Active segment byte source; ptr_q holds the granted source during a frame.
    always_comb begin
        seg_valid_c = 1'b0;
        seg_data_c  = '0;
        seg_last_c  = '0;
        case (state_q)
            S_ETH: begin
                seg_valid_c = eth_valid_i;
                seg_data_c  = eth_data_i;
                seg_last_c  = BYTE_W'(ETH_HDR_LEN - 1);
            end
            S_IP: begin
                seg_valid_c = ip_valid_i;
                seg_data_c  = ip_data_i;
                seg_last_c  = BYTE_W'(IP_HDR_LEN - 1);
            end
            S_UDP: begin
                seg_valid_c = udp_valid_i;
                seg_data_c  = udp_data_i;
                seg_last_c  = BYTE_W'(UDP_HDR_LEN - 1);
            end
            S_PAY: begin
                seg_last_c = BYTE_W'(PAYLOAD_LEN - 1);
                for (int unsigned s = 0; s < NUM_SRC; s++) begin
                    if (ptr_q == SRC_W'(s)) begin
                        seg_valid_c = pay_valid_i[s];
                        seg_data_c  = pay_data_i[8*s +: 8];
                    end
                end
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        byte_cnt_d  = byte_cnt_q;
        to_cnt_d    = to_cnt_q;
        ifg_cnt_d   = ifg_cnt_q;
        eth_start_d = 1'b0;
        ip_start_d  = 1'b0;
        udp_start_d = 1'b0;
        pay_start_d = '0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        tx_sof_d    = 1'b0;
        tx_eof_d    = 1'b0;
        err_d       = 1'b0;
        frames_d    = frames_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found_c) begin
                    state_d     = S_ETH;
                    ptr_d       = arb_idx_c;
                    grant_d     = NUM_SRC'(1) << arb_idx_c;
                    eth_start_d = 1'b1;
                    byte_cnt_d  = '0;
                    to_cnt_d    = '0;
                end
            end
            S_ETH, S_IP, S_UDP, S_PAY: begin
                if (seg_valid_c) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = seg_data_c;
                    tx_sof_d   = (state_q == S_ETH) && (byte_cnt_q == '0);
                    to_cnt_d   = '0;
                    if (byte_cnt_q == seg_last_c) begin
                        byte_cnt_d = '0;
                        case (state_q)
                            S_ETH: begin
                                state_d    = S_IP;
                                ip_start_d = 1'b1;
                            end
                            S_IP: begin
                                state_d     = S_UDP;
                                udp_start_d = 1'b1;
                            end
                            S_UDP: begin
                                state_d     = S_PAY;
                                pay_start_d = grant_q;
                            end
                            default: begin
                                state_d   = S_IFG;
                                grant_d   = '0;
                                ifg_cnt_d = '0;
                                tx_eof_d  = 1'b1;
                                frames_d  = frames_q + 16'd1;
                            end
                        endcase
                    end else begin
                        byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // Stalled generator: drop the frame, still observe the gap.
                    err_d      = 1'b1;
                    state_d    = S_IFG;
                    grant_d    = '0;
                    byte_cnt_d = '0;
                    to_cnt_d   = '0;
                    ifg_cnt_d  = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_IFG: begin
                if (ifg_cnt_q == IFG_W'(IFG_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    ifg_cnt_d = '0;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            ptr_q       <= SRC_W'(NUM_SRC - 1);
            byte_cnt_q  <= '0;
            to_cnt_q    <= '0;
            ifg_cnt_q   <= '0;
            eth_start_q <= 1'b0;
            ip_start_q  <= 1'b0;
            udp_start_q <= 1'b0;
            pay_start_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_sof_q    <= 1'b0;
            tx_eof_q    <= 1'b0;
            err_q       <= 1'b0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
            eth_start_q <= eth_start_d;
            ip_start_q  <= ip_start_d;
            udp_start_q <= udp_start_d;
            pay_start_q <= pay_start_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_sof_q    <= tx_sof_d;
            tx_eof_q    <= tx_eof_d;
            err_q       <= err_d;
            frames_q    <= frames_d;
        end
    end

    assign grant_o       = grant_q;
    assign eth_start_o   = eth_start_q;
    assign ip_start_o    = ip_start_q;
    assign udp_start_o   = udp_start_q;
    assign pay_start_o   = pay_start_q;
    assign tx_data_o     = tx_data_q;
    assign tx_valid_o    = tx_valid_q;
    assign tx_sof_o      = tx_sof_q;
    assign tx_eof_o      = tx_eof_q;
    assign err_timeout_o = err_q;
    assign frames_sent_o = frames_q;

endmodule

// File: tb/tb_eth_tx_frame_sequencer.sv
// Directed bench for eth_tx_frame_sequencer: behavioural header/payload generators,
// a tx-stream monitor and a linear sequence of checked scenarios.
module tb_eth_tx_frame_sequencer;

    localparam int NSRC = 2;
    localparam int ETH_LEN = 14;
    localparam int IP_LEN = 20;
    localparam int UDP_LEN = 8;
    localparam int PAY_LEN = 18;
    localparam int FRAME_LEN = 60;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NSRC-1:0]   req_i = '0;
    logic [NSRC-1:0]   grant_o;
    logic              eth_start_o, ip_start_o, udp_start_o;
    logic [7:0]        eth_data_i, ip_data_i, udp_data_i;
    logic              eth_valid_i, ip_valid_i, udp_valid_i;
    logic [NSRC-1:0]   pay_start_o;
    logic [8*NSRC-1:0] pay_data_i;
    logic [NSRC-1:0]   pay_valid_i;
    logic [7:0]        tx_data_o;
    logic              tx_valid_o, tx_sof_o, tx_eof_o, err_timeout_o;
    logic [15:0]       frames_sent_o;

    bit   udp_gap = 1'b0;
    bit   ip_dead = 1'b0;
    bit   noise_en = 1'b0;
    int   cyc = 0;
    int   ip_start_cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [7:0]      rx_d[$];
    bit              rx_sof[$];
    bit              rx_eof[$];
    logic [NSRC-1:0] gq[$];

    eth_tx_frame_sequencer dut (
        .clk(clk), .rst(rst), .req_i(req_i), .grant_o(grant_o),
        .eth_start_o(eth_start_o), .eth_data_i(eth_data_i), .eth_valid_i(eth_valid_i),
        .ip_start_o(ip_start_o), .ip_data_i(ip_data_i), .ip_valid_i(ip_valid_i),
        .udp_start_o(udp_start_o), .udp_data_i(udp_data_i), .udp_valid_i(udp_valid_i),
        .pay_start_o(pay_start_o), .pay_data_i(pay_data_i), .pay_valid_i(pay_valid_i),
        .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_sof_o(tx_sof_o),
        .tx_eof_o(tx_eof_o), .err_timeout_o(err_timeout_o), .frames_sent_o(frames_sent_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Byte k of the frame sent by source src; IP starts 45 00 00 2E (total length 46).
    function automatic logic [7:0] exp_byte(input int src, input int k);
        if (k < 14) return 8'(16 + k);
        if (k < 34) begin
            case (k - 14)
                0:       return 8'h45;
                1, 2:    return 8'h00;
                3:       return 8'h2E;
                default: return 8'(80 + k - 14);
            endcase
        end
        if (k < 42) return 8'(192 + k - 34);
        return 8'(128 + 32 * src + k - 42);
    endfunction

    initial begin : gen_eth
        eth_valid_i = 1'b0;
        eth_data_i  = '0;
        forever begin
            @(negedge clk);
            eth_valid_i = 1'b0;
            if (eth_start_o && !rst) begin
                for (int i = 0; i < ETH_LEN; i++) begin
                    @(negedge clk);
                    if (rst) break;
                    eth_valid_i = 1'b1;
                    eth_data_i  = exp_byte(0, i);
                end
            end
        end
    end

    initial begin : gen_ip
        ip_valid_i = 1'b0;
        ip_data_i  = '0;
        forever begin
            @(negedge clk);
            ip_valid_i = 1'b0;
            if (ip_start_o && !rst && !ip_dead) begin
                for (int i = 0; i < IP_LEN; i++) begin
                    @(negedge clk);
                    if (rst) break;
                    ip_valid_i = 1'b1;
                    ip_data_i  = exp_byte(0, ETH_LEN + i);
                end
            end
        end
    end

    initial begin : gen_udp
        udp_valid_i = 1'b0;
        udp_data_i  = '0;
        forever begin
            @(negedge clk);
            udp_valid_i = 1'b0;
            if (udp_start_o && !rst) begin
                for (int i = 0; i < UDP_LEN; i++) begin
                    @(negedge clk);
                    if (rst) break;
                    if (udp_gap && i == 4) begin
                        udp_valid_i = 1'b0;
                        repeat (3) @(negedge clk);
                    end
                    udp_valid_i = 1'b1;
                    udp_data_i  = exp_byte(0, ETH_LEN + IP_LEN + i);
                end
            end
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        localparam bit NOISY = (s == 1);
        logic       v;
        logic [7:0] d;
        assign pay_valid_i[s]      = v;
        assign pay_data_i[8*s +: 8] = d;
        initial begin
            v = 1'b0;
            d = '0;
            forever begin
                @(negedge clk);
                v = NOISY && noise_en && !v;
                d = 8'hEE;
                if (pay_start_o[s] && !rst) begin
                    for (int i = 0; i < PAY_LEN; i++) begin
                        @(negedge clk);
                        if (rst) break;
                        v = 1'b1;
                        d = exp_byte(s, ETH_LEN + IP_LEN + UDP_LEN + i);
                    end
                end
            end
        end
    end

    // Tx stream and grant capture.
    initial forever begin
        @(negedge clk);
        if (tx_valid_o) begin
            rx_d.push_back(tx_data_o);
            rx_sof.push_back(tx_sof_o);
            rx_eof.push_back(tx_eof_o);
        end
        if (eth_start_o) gq.push_back(grant_o);
        if (ip_start_o) ip_start_cyc = cyc;
    end

    initial begin : watchdog
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_d.delete();
        rx_sof.delete();
        rx_eof.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, 32'({grant_o, pay_start_o, eth_start_o, ip_start_o, udp_start_o, tx_valid_o,
                        tx_sof_o, tx_eof_o, err_timeout_o, tx_data_o}), 32'd0);
        check({tag, "_frames"}, 32'(frames_sent_o), 32'd0);
    endtask

    task automatic wait_grant();
        bit got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (grant_o != '0) begin
                got = 1'b1;
                break;
            end
        end
        check("grant_wait", 32'(got), 32'd1);
    endtask

    task automatic wait_end();
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tx_eof_o || err_timeout_o) begin
                got = 1'b1;
                break;
            end
        end
        check("end_wait", 32'(got), 32'd1);
    endtask

    task automatic check_frame(input int src, input int fs);
        int bad = 0;
        check("frame_len", 32'(rx_d.size()), 32'(FRAME_LEN));
        for (int k = 0; k < rx_d.size(); k++) begin
            if (rx_d[k] !== exp_byte(src, k) || rx_sof[k] != (k == 0) || rx_eof[k] != (k == FRAME_LEN - 1))
                bad++;
        end
        check("frame_bytes", 32'(bad), 32'd0);
        check("frames_sent", 32'(frames_sent_o), 32'(fs));
        check("err_clear", 32'(err_timeout_o), 32'd0);
    endtask

    task automatic check_gap();
        int bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (grant_o != '0) bad++;
            step();
        end
        check("ifg_grant0", 32'(bad), 32'd0);
    endtask

    task automatic run_frame(input logic [NSRC-1:0] r, input int src, input int fs);
        clear_rx();
        gq.delete();
        req_i = r;
        wait_grant();
        check("grant", 32'(grant_o), 32'(1 << src));
        req_i = '0;
        wait_end();
        check_frame(src, fs);
        check_gap();
    endtask

    initial begin : main
        rst = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Single frame from source 0, request dropped after grant.
        run_frame(2'b01, 0, 1);
        check("ip_b14", 32'(rx_d[14]), 32'h45);
        check("ip_b15", 32'(rx_d[15]), 32'h00);
        check("ip_b16", 32'(rx_d[16]), 32'h00);
        check("ip_b17", 32'(rx_d[17]), 32'h2E);

        rst = 1'b1;
        step();
        check_reset_outputs("reset2");
        rst = 1'b0;
        step();

        // Both sources requesting: alternate 01,10,01,10.
        clear_rx();
        gq.delete();
        req_i = 2'b11;
        for (int f = 0; f < 4; f++) begin
            wait_end();
            check_frame(f % 2, f + 1);
            check("rr_grant", 32'(gq.size() > f ? gq[f] : 2'b00), 32'((f % 2 == 0) ? 2'b01 : 2'b10));
            if (f == 3) req_i = '0;
            check_gap();
            clear_rx();
        end

        // IP generator silent: abort 64 cycles after ip_start.
        ip_dead = 1'b1;
        clear_rx();
        req_i = 2'b01;
        wait_grant();
        req_i = '0;
        wait_end();
        check("abort_err", 32'(err_timeout_o), 32'd1);
        check("abort_delay", 32'(cyc - ip_start_cyc), 32'd64);
        check("abort_grant", 32'({grant_o, tx_valid_o, tx_eof_o}), 32'd0);
        check("abort_bytes", 32'(rx_d.size()), 32'(ETH_LEN));
        check("abort_frames", 32'(frames_sent_o), 32'd4);
        step();
        check("abort_pulse", 32'(err_timeout_o), 32'd0);
        ip_dead = 1'b0;
        repeat (11) step();

        // UDP header with a 3-cycle valid gap.
        udp_gap = 1'b1;
        run_frame(2'b01, 0, 5);
        udp_gap = 1'b0;

        // Ungranted source 1 toggling its valid.
        noise_en = 1'b1;
        run_frame(2'b01, 0, 6);
        noise_en = 1'b0;

        // Reset while payload byte 5 is in flight.
        clear_rx();
        req_i = 2'b01;
        begin
            bit got = 1'b0;
            for (int i = 0; i < 200; i++) begin
                step();
                if (rx_d.size() >= 47) begin
                    got = 1'b1;
                    break;
                end
            end
            check("pay5_wait", 32'(got), 32'd1);
        end
        req_i = '0;
        rst = 1'b1;
        step();
        check_reset_outputs("midreset");
        rst = 1'b0;
        step();
        run_frame(2'b11, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
